csp_fair_grant_arb: RTL

CSP_FAIR_GRANT_ARB -- requirements
Module: csp_fair_grant_arb

---
 rtl/csp_fair_grant_arb_if.sv | 23 ++
 rtl/csp_fair_grant_arb.sv | 139 +++++++++++++
 2 files changed

// File: rtl/csp_fair_grant_arb_if.sv
// Request/grant bundle between the guard sources/consumer and the fair arbiter.
interface csp_fair_grant_arb_if #(
  parameter int GUARDS = 4
);
  localparam int IDX_W = (GUARDS > 1) ? $clog2(GUARDS) : 1;

  logic [GUARDS-1:0] req;
  logic              grant_ack;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [GUARDS-1:0] grant_onehot;
  logic              err;

  modport master (
    output req, grant_ack,
    input  grant_valid, grant_idx, grant_onehot, err
  );

  modport slave (
    input  req, grant_ack,
    output grant_valid, grant_idx, grant_onehot, err
  );
endinterface

// File: rtl/csp_fair_grant_arb.sv
// Fair CSP guard arbiter: longest-waiting true guard wins, LFSR-rotated tie-break.
module csp_fair_grant_lane #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic             eval,
  input  logic             snap_bit,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] upd
);
  // Saturates instead of wrapping so a starved guard never loses its seniority.
  assign upd = !snap_bit ? '0 : ((&cnt) ? cnt : cnt + CNT_W'(1));

  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET)   cnt <= '0;
    else if (eval) cnt <= upd;
    else if (clr)  cnt <= '0;
endmodule

module csp_fair_grant_arb #(
  parameter int          GUARDS = 4,
  parameter int          CNT_W  = 8,
  parameter logic [15:0] SEED   = 16'h0001
) (
  input  logic                 CLK,
  input  logic                 _RESET,
  csp_fair_grant_arb_if.slave  bus
);
  localparam int          IDX_W     = (GUARDS > 1) ? $clog2(GUARDS) : 1;
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, GRANT = 2'd2} state_t;

  state_t                        state, nstate;
  logic [GUARDS-1:0]             snap;
  logic [15:0]                   lfsr;
  logic [IDX_W-1:0]              grant_idx_q;
  logic                          err_q;
  logic                          capture, eval, accept, valid;
  logic [GUARDS-1:0]             clr_vec;
  logic [GUARDS-1:0][CNT_W-1:0]  history, upd;
  logic [CNT_W-1:0]              max_cnt;
  logic [GUARDS-1:0]             cand;
  logic [IDX_W-1:0]              sel;
  logic [7:0]                    ptr;
  logic                          found;
  int                            j;

  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) state <= IDLE;
    else         state <= nstate;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (|bus.req)     nstate = EVAL;
      EVAL:                      nstate = GRANT;
      GRANT:   if (bus.grant_ack) nstate = IDLE;
      default:                   nstate = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    eval    = 1'b0;
    accept  = 1'b0;
    valid   = 1'b0;
    case (state)
      IDLE:  capture = |bus.req;
      EVAL:  eval    = 1'b1;
      GRANT: begin
        valid  = 1'b1;
        accept = bus.grant_ack;
      end
      default: ;
    endcase
  end

  assign clr_vec = accept ? (GUARDS'(1) << grant_idx_q) : '0;

  for (genvar g = 0; g < GUARDS; g++) begin : g_lane
    csp_fair_grant_lane #(.CNT_W(CNT_W)) u_lane (
      .CLK      (CLK),
      ._RESET   (_RESET),
      .eval     (eval),
      .snap_bit (snap[g]),
      .clr      (clr_vec[g]),
      .cnt      (history[g]),
      .upd      (upd[g])
    );
  end

  always_comb begin
    max_cnt = '0;
    for (int i = 0; i < GUARDS; i++)
      if (snap[i] && upd[i] > max_cnt) max_cnt = upd[i];
  end

  always_comb begin
    for (int i = 0; i < GUARDS; i++)
      cand[i] = snap[i] && (upd[i] == max_cnt);
  end

  // Rotating first-candidate search starting at the LFSR pointer.
  assign ptr = lfsr[7:0] % 8'(GUARDS);

  always_comb begin
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < GUARDS; k++) begin
      j = (int'(ptr) + k) % GUARDS;
      if (!found && cand[IDX_W'(j)]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) begin
      snap        <= '0;
      lfsr        <= LFSR_INIT;
      grant_idx_q <= '0;
      err_q       <= 1'b0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (capture) snap        <= bus.req;
      if (eval)    grant_idx_q <= sel;
      if (valid && !bus.req[grant_idx_q]) err_q <= 1'b1;
    end

  assign bus.grant_valid  = valid;
  assign bus.grant_idx    = grant_idx_q;
  assign bus.grant_onehot = valid ? (GUARDS'(1) << grant_idx_q) : '0;
  assign bus.err          = err_q;
endmodule
